// File: rtl/criq_alloc_sched_pkg.sv
// Shared types and defaults for the CRIQ allocation scheduler.
package criq_alloc_sched_pkg;

  localparam int unsigned CRIQWIDE_DEF = 5;
  localparam int unsigned NREQ_DEF     = 2;
  localparam int unsigned NREL_DEF     = 2;
  localparam int unsigned RELDEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // Index width that stays at least one bit wide for single-entry structures.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/criq_alloc_sched_if.sv
// Requester, release and CRIQ-pool signals of the allocation scheduler.
interface criq_alloc_sched_if #(
  parameter int unsigned CRIQWIDE = criq_alloc_sched_pkg::CRIQWIDE_DEF,
  parameter int unsigned NREQ     = criq_alloc_sched_pkg::NREQ_DEF,
  parameter int unsigned NREL     = criq_alloc_sched_pkg::NREL_DEF
);
  import criq_alloc_sched_pkg::*;

  localparam int unsigned PORTW = clog2_min1(NREQ);

  logic [NREQ-1:0]          AllocReq;
  logic [NREQ-1:0]          AllocGnt;
  logic                     AllocValid;
  logic [PORTW-1:0]         AllocPort;
  logic [CRIQWIDE-1:0]      AllocIdx;
  logic [NREL-1:0]          RelValid;
  logic [NREL*CRIQWIDE-1:0] RelIdx;
  logic                     RelReady;
  logic                     FlushReq;
  logic                     FlushBusy;
  logic                     CriqRable;
  logic                     CriqWable;
  logic [CRIQWIDE-1:0]      CriqDin;
  logic                     CriqClean;
  logic [CRIQWIDE-1:0]      CriqDout;
  logic                     CriqFull;
  logic                     CriqEmpty;

  modport slave (
    input  AllocReq, RelValid, RelIdx, FlushReq, CriqDout, CriqFull, CriqEmpty,
    output AllocGnt, AllocValid, AllocPort, AllocIdx, RelReady, FlushBusy,
           CriqRable, CriqWable, CriqDin, CriqClean
  );

  modport master (
    output AllocReq, RelValid, RelIdx, FlushReq, CriqDout, CriqFull, CriqEmpty,
    input  AllocGnt, AllocValid, AllocPort, AllocIdx, RelReady, FlushBusy,
           CriqRable, CriqWable, CriqDin, CriqClean
  );

endinterface

// File: rtl/criq_alloc_sched_rel.sv
// Release buffer: FIFO with NREL-wide compacting enqueue, single pop and clear.
module criq_rel_buf
  import criq_alloc_sched_pkg::*;
#(
  parameter int unsigned CRIQWIDE = CRIQWIDE_DEF,
  parameter int unsigned NREL     = NREL_DEF,
  parameter int unsigned RELDEPTH = RELDEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic [NREL-1:0]          i_enq_valid,
  input  logic [NREL*CRIQWIDE-1:0] i_enq_idx,
  input  logic                     i_pop,
  output logic [CRIQWIDE-1:0]      o_head,
  output logic                     o_empty,
  output logic                     o_room
);

  localparam int unsigned PTRW = clog2_min1(RELDEPTH);
  localparam int unsigned CNTW = $clog2(RELDEPTH + 1);

  logic [CRIQWIDE-1:0] r_mem [RELDEPTH];
  logic [PTRW-1:0]     r_rd_ptr;
  logic [PTRW-1:0]     r_wr_ptr;
  logic [CNTW-1:0]     r_count;
  logic [CNTW-1:0]     w_n_enq;
  logic [PTRW-1:0]     w_slot [NREL];

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_room  = (32'(RELDEPTH) - 32'(r_count)) >= 32'(NREL);

  // Valid ports land in consecutive slots, lowest port first.
  always_comb begin
    w_n_enq = '0;
    for (int unsigned k = 0; k < NREL; k++) begin
      w_slot[k] = PTRW'((32'(r_wr_ptr) + 32'(w_n_enq)) % RELDEPTH);
      if (i_enq_valid[k]) w_n_enq = w_n_enq + CNTW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear) begin
      for (int unsigned k = 0; k < NREL; k++) begin
        if (i_enq_valid[k]) r_mem[w_slot[k]] <= i_enq_idx[k*CRIQWIDE +: CRIQWIDE];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= PTRW'((32'(r_wr_ptr) + 32'(w_n_enq)) % RELDEPTH);
      if (i_pop) r_rd_ptr <= PTRW'((32'(r_rd_ptr) + 32'd1) % RELDEPTH);
      r_count <= r_count + w_n_enq - CNTW'(i_pop);
    end
  end

endmodule

// File: rtl/criq_alloc_sched.sv
// Shares one CRIQ free-index pool between round-robin allocators and buffered
// release ports, and sequences the pool flush.
module criq_alloc_sched
  import criq_alloc_sched_pkg::*;
#(
  parameter int unsigned CRIQWIDE = CRIQWIDE_DEF,
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned NREL     = NREL_DEF,
  parameter int unsigned RELDEPTH = RELDEPTH_DEF
) (
  input  logic               Clk,
  input  logic               Rest,
  criq_alloc_sched_if.slave  bus
);

  localparam int unsigned PORTW = clog2_min1(NREQ);

  sched_state_e        r_state;
  logic [PORTW-1:0]    r_rr_ptr;
  logic [PORTW-1:0]    r_alloc_port;
  logic                r_alloc_valid;

  logic                w_run;
  logic                w_flush_go;
  logic [NREQ-1:0]     w_gnt;
  logic [PORTW-1:0]    w_gnt_idx;
  logic [PORTW-1:0]    w_sel;
  logic                w_gnt_any;
  logic                w_rel_ready;
  logic                w_rel_room;
  logic                w_rel_empty;
  logic                w_rel_pop;
  logic [CRIQWIDE-1:0] w_rel_head;
  logic [NREL-1:0]     w_rel_enq;

  // Reset is async, so gate on it to keep grants low while it is held.
  assign w_run      = (r_state == ST_RUN) && !Rest;
  assign w_flush_go = w_run && bus.FlushReq;

  // Round-robin: first requester at or after the pointer.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_sel     = '0;
    if (w_run && !bus.CriqEmpty) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        w_sel = PORTW'((32'(r_rr_ptr) + off) % NREQ);
        if (!w_gnt_any && bus.AllocReq[w_sel]) begin
          w_gnt_any    = 1'b1;
          w_gnt_idx    = w_sel;
          w_gnt[w_sel] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_state       <= ST_RUN;
      r_rr_ptr      <= '0;
      r_alloc_port  <= '0;
      r_alloc_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN:   if (bus.FlushReq) r_state <= ST_FLUSH;
        ST_FLUSH: r_state <= ST_DRAIN;
        ST_DRAIN: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
      // A read issued as the flush starts returns a stale index; drop it.
      r_alloc_valid <= w_gnt_any && !w_flush_go;
      if (w_gnt_any) begin
        r_rr_ptr     <= PORTW'((32'(w_gnt_idx) + 32'd1) % NREQ);
        r_alloc_port <= w_gnt_idx;
      end
    end
  end

  assign w_rel_ready = (r_state == ST_RUN) && w_rel_room;
  assign w_rel_enq   = bus.RelValid & {NREL{w_rel_ready}};
  assign w_rel_pop   = w_run && !w_rel_empty && !bus.CriqFull;

  criq_rel_buf #(
    .CRIQWIDE (CRIQWIDE),
    .NREL     (NREL),
    .RELDEPTH (RELDEPTH)
  ) u_rel_buf (
    .i_clk       (Clk),
    .i_rst       (Rest),
    .i_clear     (r_state == ST_FLUSH),
    .i_enq_valid (w_rel_enq),
    .i_enq_idx   (bus.RelIdx),
    .i_pop       (w_rel_pop),
    .o_head      (w_rel_head),
    .o_empty     (w_rel_empty),
    .o_room      (w_rel_room)
  );

  assign bus.AllocGnt   = w_gnt;
  assign bus.CriqRable  = w_gnt_any;
  assign bus.AllocValid = r_alloc_valid;
  assign bus.AllocPort  = r_alloc_port;
  assign bus.AllocIdx   = bus.CriqDout;
  assign bus.RelReady   = w_rel_ready;
  assign bus.CriqWable  = w_rel_pop;
  assign bus.CriqDin    = w_rel_head;
  assign bus.CriqClean  = (r_state == ST_FLUSH);
  assign bus.FlushBusy  = (r_state != ST_RUN);

endmodule

// File: tb/tb_criq_alloc_sched.sv
// Directed bench for criq_alloc_sched with a behavioural CRIQ pool and scoreboards.
module tb_criq_alloc_sched;
  import criq_alloc_sched_pkg::*;

  localparam int unsigned W       = 5;
  localparam int unsigned NQ      = 2;
  localparam int unsigned NL      = 2;
  localparam int unsigned DEP     = 4;
  localparam int          POOLCAP = 32;

  typedef struct packed {
    logic [0:0]   port;
    logic [W-1:0] idx;
  } alloc_t;

  logic Clk  = 1'b0;
  logic Rest = 1'b0;
  always #5 Clk = ~Clk;

  criq_alloc_sched_if #(.CRIQWIDE(W), .NREQ(NQ), .NREL(NL)) bus ();

  criq_alloc_sched #(.CRIQWIDE(W), .NREQ(NQ), .NREL(NL), .RELDEPTH(DEP)) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  alloc_t       exp_alloc [$];
  logic [W-1:0] exp_wr    [$];
  logic [W-1:0] pool      [$];
  int           pool_n    = 0;
  logic         force_full = 1'b0;
  logic [W-1:0] dout_r    = '0;

  assign bus.CriqDout  = dout_r;
  assign bus.CriqFull  = (pool_n >= POOLCAP) || force_full;
  assign bus.CriqEmpty = (pool_n == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_alloc(input logic [0:0] p, input logic [W-1:0] i);
    alloc_t a;
    a.port = p;
    a.idx  = i;
    exp_alloc.push_back(a);
  endtask

  // Pool model: circular free list with registered read, reloaded by clean/reset.
  always @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      pool = '{5'd3, 5'd7, 5'd11, 5'd15};
      dout_r <= '0;
    end else if (bus.CriqClean) begin
      pool = '{5'd3, 5'd7, 5'd11, 5'd15};
    end else begin
      if (bus.CriqRable && pool.size() > 0) dout_r <= pool.pop_front();
      if (bus.CriqWable) pool.push_back(bus.CriqDin);
    end
    pool_n <= pool.size();
  end

  // Scoreboard side: compare every allocation result and pool write.
  always @(negedge Clk) begin : mon
    alloc_t       ea;
    logic [W-1:0] ew;
    #2;
    if (bus.AllocValid === 1'b1) begin
      chk("alloc_sb_nonempty", 32'(exp_alloc.size() != 0), 32'd1);
      if (exp_alloc.size() != 0) begin
        ea = exp_alloc.pop_front();
        chk("alloc_port", 32'(bus.AllocPort), 32'(ea.port));
        chk("alloc_idx", 32'(bus.AllocIdx), 32'(ea.idx));
      end
    end
    if (bus.CriqWable === 1'b1) begin
      chk("wr_sb_nonempty", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        ew = exp_wr.pop_front();
        chk("pool_din", 32'(bus.CriqDin), 32'(ew));
      end
    end
  end

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog observed=timeout expected=finish");
  end

  initial begin
    logic [1:0]   gseq [4];
    logic [W-1:0] iseq [4];
    gseq = '{2'b01, 2'b10, 2'b01, 2'b10};
    iseq = '{5'd3, 5'd7, 5'd11, 5'd15};
    bus.AllocReq = '0;
    bus.RelValid = '0;
    bus.RelIdx   = '0;
    bus.FlushReq = 1'b0;
    #1 Rest = 1'b1;
    @(negedge Clk); @(negedge Clk); #1;
    chk("rst_gnt", 32'(bus.AllocGnt), 0);
    chk("rst_valid", 32'(bus.AllocValid), 0);
    chk("rst_rable", 32'(bus.CriqRable), 0);
    chk("rst_wable", 32'(bus.CriqWable), 0);
    chk("rst_clean", 32'(bus.CriqClean), 0);
    chk("rst_busy", 32'(bus.FlushBusy), 0);
    chk("rst_port", 32'(bus.AllocPort), 0);
    chk("rst_relready", 32'(bus.RelReady), 1);

    // Round-robin over a preloaded pool.
    @(negedge Clk); Rest = 1'b0; bus.AllocReq = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge Clk);
      #1;
      chk($sformatf("t1_gnt%0d", i), 32'(bus.AllocGnt), 32'(gseq[i]));
      chk($sformatf("t1_rable%0d", i), 32'(bus.CriqRable), 1);
      push_alloc(1'(i % 2), iseq[i]);
    end

    // Empty pool blocks grants.
    @(negedge Clk); #1;
    chk("t2_gnt_empty", 32'(bus.AllocGnt), 0);
    chk("t2_rable_empty", 32'(bus.CriqRable), 0);

    // Two releases drain in port order and refill the pool.
    @(negedge Clk); bus.RelValid = 2'b11; bus.RelIdx = {5'd7, 5'd3}; #1;
    chk("t3_relready", 32'(bus.RelReady), 1);
    chk("t3_gnt_empty", 32'(bus.AllocGnt), 0);
    chk("t3_wable_idle", 32'(bus.CriqWable), 0);
    exp_wr.push_back(5'd3); exp_wr.push_back(5'd7);
    @(negedge Clk); bus.RelValid = '0; #1;
    chk("t3_wable0", 32'(bus.CriqWable), 1);
    chk("t3_gnt_still0", 32'(bus.AllocGnt), 0);
    @(negedge Clk); #1;
    chk("t3_wable1", 32'(bus.CriqWable), 1);
    chk("t3_gnt_refill", 32'(bus.AllocGnt), 2'b01);
    push_alloc(1'b0, 5'd3);
    @(negedge Clk); #1;
    chk("t3_wable_done", 32'(bus.CriqWable), 0);
    chk("t3_gnt_next", 32'(bus.AllocGnt), 2'b10);
    push_alloc(1'b1, 5'd7);

    // Full pool holds four buffered releases; overflow attempt is dropped.
    @(negedge Clk); bus.AllocReq = '0; force_full = 1'b1;
    bus.RelValid = 2'b11; bus.RelIdx = {5'd21, 5'd20}; #1;
    chk("t4_relready0", 32'(bus.RelReady), 1);
    exp_wr.push_back(5'd20); exp_wr.push_back(5'd21);
    @(negedge Clk); bus.RelIdx = {5'd23, 5'd22}; #1;
    chk("t4_relready2", 32'(bus.RelReady), 1);
    chk("t4_wable_full", 32'(bus.CriqWable), 0);
    exp_wr.push_back(5'd22); exp_wr.push_back(5'd23);
    @(negedge Clk); bus.RelValid = 2'b01; bus.RelIdx = {5'd0, 5'd30}; #1;
    chk("t4_relready4", 32'(bus.RelReady), 0);
    chk("t4_wable_hold", 32'(bus.CriqWable), 0);
    @(negedge Clk); bus.RelValid = '0; #1;
    chk("t4_relready_drop", 32'(bus.RelReady), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      force_full = 1'b0;
      #1;
      chk($sformatf("t4_wable%0d", i), 32'(bus.CriqWable), 1);
    end
    @(negedge Clk); #1;
    chk("t4_wable_end", 32'(bus.CriqWable), 0);
    chk("t4_relready_end", 32'(bus.RelReady), 1);

    // Flush with a grant in flight and two buffered releases.
    @(negedge Clk); force_full = 1'b1; bus.RelValid = 2'b11; bus.RelIdx = {5'd25, 5'd24}; #1;
    chk("t5_relready", 32'(bus.RelReady), 1);
    @(negedge Clk); bus.RelValid = '0; bus.AllocReq = 2'b01; bus.FlushReq = 1'b1; #1;
    chk("t5_gnt_inflight", 32'(bus.AllocGnt), 2'b01);
    chk("t5_busy_pre", 32'(bus.FlushBusy), 0);
    @(negedge Clk); force_full = 1'b0; #1;
    chk("t5_clean", 32'(bus.CriqClean), 1);
    chk("t5_busy_flush", 32'(bus.FlushBusy), 1);
    chk("t5_valid_killed", 32'(bus.AllocValid), 0);
    chk("t5_gnt_flush", 32'(bus.AllocGnt), 0);
    chk("t5_wable_flush", 32'(bus.CriqWable), 0);
    @(negedge Clk); #1;
    chk("t5_clean_drain", 32'(bus.CriqClean), 0);
    chk("t5_busy_drain", 32'(bus.FlushBusy), 1);
    chk("t5_relready_drain", 32'(bus.RelReady), 0);
    chk("t5_gnt_drain", 32'(bus.AllocGnt), 0);
    @(negedge Clk); bus.FlushReq = 1'b0; #1;
    chk("t5_busy_run", 32'(bus.FlushBusy), 0);
    chk("t5_gnt_resume", 32'(bus.AllocGnt), 2'b01);
    chk("t5_wable_cleared", 32'(bus.CriqWable), 0);
    push_alloc(1'b0, 5'd3);
    @(negedge Clk); bus.AllocReq = '0; #1;
    chk("t5_wable_after", 32'(bus.CriqWable), 0);

    // Reset in the middle of draining two releases.
    @(negedge Clk); bus.RelValid = 2'b11; bus.RelIdx = {5'd10, 5'd9}; #1;
    exp_wr.push_back(5'd9);
    @(negedge Clk); bus.RelValid = '0; #1;
    chk("t6_wable_pre", 32'(bus.CriqWable), 1);
    #2 Rest = 1'b1; bus.AllocReq = 2'b11; #1;
    chk("t6_wable_rst", 32'(bus.CriqWable), 0);
    chk("t6_relready_rst", 32'(bus.RelReady), 1);
    chk("t6_gnt_rst", 32'(bus.AllocGnt), 0);
    chk("t6_rable_rst", 32'(bus.CriqRable), 0);
    chk("t6_valid_rst", 32'(bus.AllocValid), 0);
    chk("t6_busy_rst", 32'(bus.FlushBusy), 0);
    @(negedge Clk); Rest = 1'b0; #1;
    chk("t6_gnt_after", 32'(bus.AllocGnt), 2'b01);
    chk("t6_wable_after", 32'(bus.CriqWable), 0);
    push_alloc(1'b0, 5'd3);
    @(negedge Clk); #1;
    chk("t6_gnt_after2", 32'(bus.AllocGnt), 2'b10);
    chk("t6_wable_after2", 32'(bus.CriqWable), 0);
    push_alloc(1'b1, 5'd7);
    @(negedge Clk); bus.AllocReq = '0; #1;
    chk("t6_wable_after3", 32'(bus.CriqWable), 0);
    @(negedge Clk); @(negedge Clk); #3;
    chk("sb_alloc_drained", 32'(exp_alloc.size()), 0);
    chk("sb_wr_drained", 32'(exp_wr.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
